// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (address, count, words, checksum),
// writes the words into program RAM and releases the CPU on a good checksum.

module program_loader_checker (
  input logic clk,
  input logic rst_n,
  input logic ready,
  input logic ram_en,
  input logic ram_rw,
  input logic halt,
  input logic done,
  input logic err
);

  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done && err));
  a_write_quiet: assert property (@(posedge clk) disable iff (!rst_n) ram_en |-> (!ram_rw && !ready));
  a_run_released: assert property (@(posedge clk) disable iff (!rst_n) done |-> !halt);
  a_err_halted: assert property (@(posedge clk) disable iff (!rst_n) err |-> halt);

endmodule

module program_loader #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int WRITE_CYCLES  = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [7:0]               BYTE_DATA,
  input  logic                     BYTE_VALID,
  output logic                     BYTE_READY,
  output logic                     HALT,
  output logic                     RAM_EN,
  output logic                     RAM_RW,
  output wire [ADDRESS_WIDTH-1:0]  ADDRESS_BUS,
  output wire [DATA_WIDTH-1:0]     DATA_BUS,
  output logic                     LOAD_DONE,
  output logic                     LOAD_ERR
);

  localparam logic [3:0] ST_ADDR_HI = 4'd0;
  localparam logic [3:0] ST_ADDR_LO = 4'd1;
  localparam logic [3:0] ST_CNT_HI  = 4'd2;
  localparam logic [3:0] ST_CNT_LO  = 4'd3;
  localparam logic [3:0] ST_DATA_HI = 4'd4;
  localparam logic [3:0] ST_DATA_LO = 4'd5;
  localparam logic [3:0] ST_WRITE   = 4'd6;
  localparam logic [3:0] ST_CKSUM   = 4'd7;
  localparam logic [3:0] ST_RUN     = 4'd8;
  localparam logic [3:0] ST_ERR     = 4'd9;

  localparam int WC_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WRITE_CYCLES - 1);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  function automatic logic is_byte_state(input logic [3:0] st);
    return (st == ST_ADDR_HI) || (st == ST_ADDR_LO) || (st == ST_CNT_HI) ||
           (st == ST_CNT_LO)  || (st == ST_DATA_HI) || (st == ST_DATA_LO) ||
           (st == ST_CKSUM);
  endfunction

  logic [3:0]               state_r;
  logic [3:0]               state_nxt_s;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [7:0]               addr_hi_r;
  logic [7:0]               cnt_hi_r;
  logic [15:0]              cnt_r;
  logic [7:0]               data_hi_r;
  logic [DATA_WIDTH-1:0]    word_r;
  logic [7:0]               sum_r;
  logic [WC_W-1:0]          wcnt_r;
  logic                     accept_s;
  logic                     write_last_s;
  logic [7:0]               sum_nxt_s;

  assign accept_s     = BYTE_VALID & BYTE_READY;
  assign write_last_s = (state_r == ST_WRITE) && (wcnt_r == WC_LAST);
  assign sum_nxt_s    = cksum_add(sum_r, BYTE_DATA);

  // Next-state decode; byte states only move on an accepted byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ADDR_HI: if (accept_s) state_nxt_s = ST_ADDR_LO; else state_nxt_s = state_r;
      ST_ADDR_LO: if (accept_s) state_nxt_s = ST_CNT_HI;  else state_nxt_s = state_r;
      ST_CNT_HI:  if (accept_s) state_nxt_s = ST_CNT_LO;  else state_nxt_s = state_r;
      ST_CNT_LO: begin
        if (accept_s) begin
          if ({cnt_hi_r, BYTE_DATA} != 16'h0000) state_nxt_s = ST_DATA_HI;
          else state_nxt_s = ST_CKSUM;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DATA_HI: if (accept_s) state_nxt_s = ST_DATA_LO; else state_nxt_s = state_r;
      ST_DATA_LO: if (accept_s) state_nxt_s = ST_WRITE;   else state_nxt_s = state_r;
      ST_WRITE: begin
        if (write_last_s) begin
          if (cnt_r == 16'h0001) state_nxt_s = ST_CKSUM;
          else state_nxt_s = ST_DATA_HI;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CKSUM: begin
        if (accept_s) begin
          if (sum_nxt_s == 8'h00) state_nxt_s = ST_RUN;
          else state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      ST_ERR:  state_nxt_s = ST_ERR;
      default: state_nxt_s = ST_ADDR_HI;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_r <= ST_ADDR_HI;
    else        state_r <= state_nxt_s;
  end

  // Header/word capture, running checksum and write-strobe timing.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_r    <= '0;
      addr_hi_r <= 8'h00;
      cnt_hi_r  <= 8'h00;
      cnt_r     <= 16'h0000;
      data_hi_r <= 8'h00;
      word_r    <= '0;
      sum_r     <= 8'h00;
      wcnt_r    <= '0;
    end else begin
      if (accept_s) begin
        sum_r <= sum_nxt_s;
        case (state_r)
          ST_ADDR_HI: addr_hi_r <= BYTE_DATA;
          ST_ADDR_LO: addr_r    <= ADDRESS_WIDTH'({addr_hi_r, BYTE_DATA});
          ST_CNT_HI:  cnt_hi_r  <= BYTE_DATA;
          ST_CNT_LO:  cnt_r     <= {cnt_hi_r, BYTE_DATA};
          ST_DATA_HI: data_hi_r <= BYTE_DATA;
          ST_DATA_LO: word_r    <= DATA_WIDTH'({data_hi_r, BYTE_DATA});
          default: ;
        endcase
      end
      if (state_r == ST_WRITE) begin
        if (write_last_s) begin
          wcnt_r <= '0;
          addr_r <= addr_r + ADDR_ONE;
          cnt_r  <= cnt_r - 16'h0001;
        end else begin
          wcnt_r <= wcnt_r + WC_ONE;
        end
      end
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BYTE_READY <= 1'b0;
      HALT       <= 1'b1;
      RAM_EN     <= 1'b0;
      RAM_RW     <= 1'b1;
      LOAD_DONE  <= 1'b0;
      LOAD_ERR   <= 1'b0;
    end else begin
      BYTE_READY <= is_byte_state(state_nxt_s);
      HALT       <= (state_nxt_s != ST_RUN);
      RAM_EN     <= (state_nxt_s == ST_WRITE);
      RAM_RW     <= (state_nxt_s != ST_WRITE);
      LOAD_DONE  <= (state_nxt_s == ST_RUN);
      LOAD_ERR   <= (state_nxt_s == ST_ERR);
    end
  end

  assign ADDRESS_BUS = RAM_EN ? addr_r : {ADDRESS_WIDTH{1'bz}};
  assign DATA_BUS    = RAM_EN ? word_r : {DATA_WIDTH{1'bz}};

  program_loader_checker u_checker (
    .clk    (CLK),
    .rst_n  (RESET),
    .ready  (BYTE_READY),
    .ram_en (RAM_EN),
    .ram_rw (RAM_RW),
    .halt   (HALT),
    .done   (LOAD_DONE),
    .err    (LOAD_ERR)
  );

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frame table, mid-write reset, and random
// frames checked against a frame-parsing reference model.

module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, sel, bvalid;
  logic [7:0] bdata;
  logic rdy1, halt1, en1, rw1, done1, err1;
  logic rdy3, halt3, en3, rw3, done3, err3;
  wire [15:0] a1, d1, a3, d3;

  program_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .WRITE_CYCLES(1)) dut1 (
    .CLK(clk), .RESET(rst1), .BYTE_DATA(bdata), .BYTE_VALID(bvalid), .BYTE_READY(rdy1),
    .HALT(halt1), .RAM_EN(en1), .RAM_RW(rw1), .ADDRESS_BUS(a1), .DATA_BUS(d1),
    .LOAD_DONE(done1), .LOAD_ERR(err1));

  program_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .WRITE_CYCLES(3)) dut3 (
    .CLK(clk), .RESET(rst3), .BYTE_DATA(bdata), .BYTE_VALID(bvalid), .BYTE_READY(rdy3),
    .HALT(halt3), .RAM_EN(en3), .RAM_RW(rw3), .ADDRESS_BUS(a3), .DATA_BUS(d3),
    .LOAD_DONE(done3), .LOAD_ERR(err3));

  wire        cur_ready = sel ? rdy3  : rdy1;
  wire        cur_halt  = sel ? halt3 : halt1;
  wire        cur_en    = sel ? en3   : en1;
  wire        cur_rw    = sel ? rw3   : rw1;
  wire        cur_done  = sel ? done3 : done1;
  wire        cur_err   = sel ? err3  : err1;
  wire [15:0] cur_a     = sel ? a3    : a1;
  wire [15:0] cur_d     = sel ? d3    : d1;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct {
    logic [127:0] bytes;
    int           n;
    bit           wc3;
    bit           gaps;
    bit           good;
    int           nw;
    logic [31:0]  first;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] frame_q[$];
  wr_t exp_q[$];
  wr_t got_q[$];
  int len_q[$];
  bit exp_good;
  int run_len = 0;
  int ready_in_strobe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit undriven(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // Reference: parse the frame directly from its byte list.
  function automatic void model();
    int unsigned s = 0;
    logic [15:0] addr, cnt;
    exp_q.delete();
    foreach (frame_q[i]) s += frame_q[i];
    exp_good = ((s % 256) == 0);
    addr = {frame_q[0], frame_q[1]};
    cnt  = {frame_q[2], frame_q[3]};
    for (int i = 0; i < int'(cnt); i++)
      exp_q.push_back({addr + 16'(i), frame_q[4 + 2*i], frame_q[5 + 2*i]});
  endfunction

  // RAM-side monitor: one entry per write strobe plus its length in cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (cur_en === 1'b1 && cur_rw === 1'b0) begin
        if (run_len == 0) got_q.push_back({cur_a, cur_d});
        run_len++;
        if (cur_ready !== 1'b0) ready_in_strobe++;
      end else if (run_len != 0) begin
        len_q.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic put_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bdata  = b;
    bvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cur_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bvalid = 1'b0;
  endtask

  task automatic start_dut(input bit s);
    rst1 = 1'b0;
    rst3 = 1'b0;
    bvalid = 1'b0;
    @(negedge clk);
    sel = s;
    if (s) rst3 = 1'b1;
    else rst1 = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(cur_ready), 32'd1);
  endtask

  task automatic run_frame(input string tag, input bit good, input bit gaps);
    int wc = sel ? 3 : 1;
    int bad = 0;
    int n0;
    bit fin_halt, fin_done, fin_err;
    got_q.delete();
    len_q.delete();
    ready_in_strobe = 0;
    foreach (frame_q[i]) begin
      if (gaps && (i % 2 == 1)) begin
        bvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (i == frame_q.size() - 1)
        check({tag, "_halt_before_cksum"}, 32'(cur_halt), 32'd1);
      put_byte(frame_q[i]);
    end
    fin_halt = cur_halt;
    fin_done = cur_done;
    fin_err  = cur_err;
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size()) check($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
    foreach (len_q[i]) if (len_q[i] != wc) bad++;
    check({tag, "_strobe_len_bad"}, 32'(bad), 32'd0);
    check({tag, "_ready_in_write"}, 32'(ready_in_strobe), 32'd0);
    check({tag, "_done"}, 32'(fin_done), 32'(good));
    check({tag, "_err"}, 32'(fin_err), 32'(!good));
    check({tag, "_halt"}, 32'(fin_halt), 32'(!good));
    check({tag, "_bus_idle"}, 32'(undriven(cur_a) && undriven(cur_d) && cur_en == 1'b0), 32'd1);
    n0 = got_q.size();
    bad = 0;
    bdata = 8'h5A;
    bvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (cur_ready !== 1'b0) bad++;
    end
    bvalid = 1'b0;
    check({tag, "_ignored_ready"}, 32'(bad), 32'd0);
    check({tag, "_ignored_nowrite"}, 32'(got_q.size()), 32'(n0));
    check({tag, "_sticky"}, {30'd0, cur_done, cur_err}, {30'd0, good, !good});
  endtask

  initial begin
    vec_t vecs[5];
    logic [15:0] addr, cnt;
    int unsigned s;
    logic [7:0] ck;

    vecs[0] = '{128'h0010_0003_0005_0000_0001_E700_0000_0000, 11, 1'b0, 1'b0, 1'b1, 3, 32'h0010_0005};
    vecs[1] = '{128'h0020_0000_E000_0000_0000_0000_0000_0000,  5, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0000};
    vecs[2] = '{128'h0010_0003_0005_0000_0001_E600_0000_0000, 11, 1'b0, 1'b0, 1'b0, 3, 32'h0010_0005};
    vecs[3] = '{128'hFFFF_0002_AAAA_5555_0200_0000_0000_0000,  9, 1'b0, 1'b0, 1'b1, 2, 32'hFFFF_AAAA};
    vecs[4] = '{128'h0010_0003_0005_0000_0001_E700_0000_0000, 11, 1'b1, 1'b1, 1'b1, 3, 32'h0010_0005};

    rst1 = 1'b0;
    rst3 = 1'b0;
    sel = 1'b0;
    bvalid = 1'b0;
    bdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_halt", 32'(halt1), 32'd1);
    check("rst_ram_en", 32'(en1), 32'd0);
    check("rst_ram_rw", 32'(rw1), 32'd1);
    check("rst_ready", 32'(rdy1), 32'd0);
    check("rst_done_err", {30'd0, done1, err1}, 32'd0);
    check("rst_bus", 32'(undriven(a1) && undriven(d1)), 32'd1);

    for (int k = 0; k < 5; k++) begin
      start_dut(vecs[k].wc3);
      frame_q.delete();
      for (int i = 0; i < vecs[k].n; i++) frame_q.push_back(vecs[k].bytes[127 - 8*i -: 8]);
      model();
      run_frame($sformatf("v%0d", k), vecs[k].good, vecs[k].gaps);
      check($sformatf("v%0d_table_nw", k), 32'(got_q.size()), 32'(vecs[k].nw));
      if (vecs[k].nw > 0 && got_q.size() > 0)
        check($sformatf("v%0d_table_first", k), got_q[0], vecs[k].first);
    end

    // Reset asserted between clock edges while the first word is being written.
    start_dut(1'b0);
    frame_q = '{8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'hE7};
    for (int i = 0; i < 6; i++) put_byte(frame_q[i]);
    check("midrst_in_write", 32'(cur_en), 32'd1);
    #2;
    rst1 = 1'b0;
    #1;
    check("midrst_ram_en", 32'(cur_en), 32'd0);
    check("midrst_halt", 32'(cur_halt), 32'd1);
    check("midrst_bus", 32'(undriven(cur_a) && undriven(cur_d)), 32'd1);
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after", 32'(cur_ready), 32'd1);
    model();
    run_frame("midrst_reload", 1'b1, 1'b0);

    for (int r = 0; r < 16; r++) begin
      start_dut(r[0]);
      frame_q.delete();
      addr = 16'($urandom);
      if ($urandom_range(0, 2) == 0) addr = 16'hFFFE;
      cnt = 16'($urandom_range(0, 5));
      frame_q.push_back(addr[15:8]);
      frame_q.push_back(addr[7:0]);
      frame_q.push_back(cnt[15:8]);
      frame_q.push_back(cnt[7:0]);
      for (int i = 0; i < 2 * int'(cnt); i++) frame_q.push_back(8'($urandom));
      s = 0;
      foreach (frame_q[i]) s += frame_q[i];
      ck = 8'((256 - (s % 256)) % 256);
      if ($urandom_range(0, 3) == 0) ck = ck + 8'($urandom_range(1, 255));
      frame_q.push_back(ck);
      model();
      run_frame($sformatf("rnd%0d", r), exp_good, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Hardware boot loader that sits directly upstream of the CPU and its program RAM.
- Accepts a framed byte stream (header, program words, checksum) over a valid/ready interface.
- Writes each 16-bit word into RAM over the shared address and data buses.
- Holds the CPU in HALT while loading. On a good checksum it releases the buses and de-asserts HALT, so the CPU runs from the loaded image.

Parameters:
- ADDRESS_WIDTH, 16: width of ADDRESS_BUS and of the internal address counter.
- DATA_WIDTH, 16: RAM word width. The frame format is fixed at 2 bytes per word, so the design requires DATA_WIDTH=16.
- WRITE_CYCLES, 1: number of clock cycles each RAM write strobe (RAM_EN=1, RAM_RW=0) is held; minimum 1.

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset (0 = in reset).
- BYTE_DATA  input  8  incoming stream byte.
- BYTE_VALID  input  1  BYTE_DATA is valid.
- BYTE_READY  output  1  loader can accept a byte this cycle.
- HALT  output  1  1 = CPU held; 0 = CPU runs.
- RAM_EN  output  1  RAM enable.
- RAM_RW  output  1  0 = write, 1 = read.
- ADDRESS_BUS  output  ADDRESS_WIDTH  RAM address; driven only while writing, high-Z otherwise.
- DATA_BUS  output  DATA_WIDTH  RAM write data; driven only while writing, high-Z otherwise.
- LOAD_DONE  output  1  image loaded and verified; sticky until reset.
- LOAD_ERR  output  1  checksum mismatch; sticky until reset.

Behaviour:
- Reset state (RESET=0), applied immediately and asynchronously:
  - HALT=1, RAM_EN=0, RAM_RW=1, BYTE_READY=0, LOAD_DONE=0, LOAD_ERR=0.
  - ADDRESS_BUS and DATA_BUS high-Z.
  - FSM returns to ADDR_HI; address counter, word counter, checksum and write-cycle counter all cleared.
- Byte handshake:
  - A byte is consumed at a rising edge where BYTE_VALID=1 and BYTE_READY=1.
  - BYTE_READY is a registered output. It is 1 only in ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO and CKSUM.
  - BYTE_READY is 1 in the first cycle after RESET releases.
  - BYTE_VALID gaps of any length stall the FSM with no state change.
- Frame format, big-endian: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words each sent as HI then LO, then one CKSUM byte.
- FSM states: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CKSUM, RUN, ERR.
  - ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO, advancing on each accepted byte.
  - CNT_LO accept: go to DATA_HI if the count is nonzero, else go to CKSUM (no RAM writes).
  - DATA_HI -> DATA_LO on an accepted byte.
  - DATA_LO accept: go to WRITE with the assembled word latched.
- WRITE state:
  - Drives RAM_EN=1, RAM_RW=0, ADDRESS_BUS=current address, DATA_BUS=word, for exactly WRITE_CYCLES cycles. BYTE_READY=0 throughout.
  - On exit: address increments (wrapping 0xFFFF -> 0x0000) and the word count decrements.
  - If the remaining count is now 0, go to CKSUM; else go to DATA_HI.
  - Outside WRITE: RAM_EN=0, RAM_RW=1, buses high-Z.
- Checksum:
  - An 8-bit running sum (mod 256) covers every accepted byte, including the CKSUM byte itself.
  - CKSUM accept with final sum == 0x00: go to RUN.
  - Any other final sum: go to ERR.
- RUN: HALT=0 and LOAD_DONE=1, both effective the cycle after the CKSUM byte is accepted. BYTE_READY=0; the stream is ignored. RUN is held until reset.
- ERR: HALT stays 1, LOAD_ERR=1, BYTE_READY=0. ERR is held until reset.
- LOAD_DONE and LOAD_ERR are never both 1.
- Count 0xFFFF is legal: 65535 writes, with the address wrapping as needed.
- Reset mid-operation (including during WRITE) aborts immediately. Any partially written image is left in RAM, and the next frame starts at ADDR_HI.

Test Plan:
- Nominal load:
  - Stimulus: bytes 00 10 00 03 00 05 00 00 00 01 E7.
  - Required: writes 0x0010=0x0005, 0x0011=0x0000, 0x0012=0x0001, each with a one-cycle RAM_EN=1/RAM_RW=0 strobe.
  - Required: HALT falls to 0 and LOAD_DONE=1 one cycle after E7 is accepted; buses high-Z afterwards.
- Zero count:
  - Stimulus: 00 20 00 00 E0.
  - Required: no RAM_EN pulse; then RUN (HALT=0, LOAD_DONE=1).
- Bad checksum:
  - Stimulus: the nominal frame with E6 as the last byte.
  - Required: the three writes still occur; then LOAD_ERR=1, HALT=1 and BYTE_READY=0 held, and further bytes are ignored.
- Address wrap:
  - Stimulus: FF FF 00 02 AA AA 55 55 02.
  - Required: writes 0xFFFF=0xAAAA, then 0x0000=0x5555; then RUN.
- Backpressure and stalls:
  - Stimulus: nominal frame with BYTE_VALID toggling 1/0, bytes offered during WRITE cycles, and WRITE_CYCLES=3.
  - Required: BYTE_READY=0 for exactly 3 cycles per word; no byte lost or duplicated; identical RAM contents to the nominal load.
- Reset mid-load:
  - Stimulus: drive RESET=0 in the middle of a WRITE cycle of the nominal frame.
  - Required: RAM_EN=0, buses high-Z and HALT=1 immediately, without waiting for a clock edge.
  - Required: after RESET releases, a full new frame loads correctly.
